icache: RTL

//  Direct-mapped instruction cache between the instruction fetcher (IF) and memctrl's INF port.
//  - Hits are served from local arrays.
//  - Misses issue one word fetch to memctrl, fill the line and forward the instruction.
//  - Removes the 5-cycle byte-serial RAM cost from every repeated fetch.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_if.sv | 24 ++
 rtl/icache_store.sv | 43 ++++
 rtl/icache.sv | 139 +++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
// Optional build macro ICACHE_PERF_EN adds hit/miss counters to the icache top.
package icache_pkg;

   localparam int ICACHE_INDEX_W = 6;

   typedef enum logic [0:0] {
      IC_IDLE = 1'b0,
      IC_MISS = 1'b1
   } ic_state_e;

   // Word-aligned memctrl address from a fetch pc.
   function automatic logic [31:0] ic_word_addr(input logic [29:0] pc_word);
      return {pc_word, 2'b00};
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetcher / memctrl-facing signal bundle of the instruction cache.
// slave = the cache, master = fetcher and memctrl side.
interface icache_if;
   logic        iIF_en;
   logic [31:0] iIF_pc;
   logic        oIF_valid;
   logic [31:0] oIF_inst;
   logic        iFLUSH;
   logic        iCLEAR;
   logic        oMC_en;
   logic [31:0] oMC_addr;
   logic        iMC_done;
   logic [31:0] iMC_inst;

   modport slave (
      input  iIF_en, iIF_pc, iFLUSH, iCLEAR, iMC_done, iMC_inst,
      output oIF_valid, oIF_inst, oMC_en, oMC_addr
   );

   modport master (
      output iIF_en, iIF_pc, iFLUSH, iCLEAR, iMC_done, iMC_inst,
      input  oIF_valid, oIF_inst, oMC_en, oMC_addr
   );
endinterface

// File: rtl/icache_store.sv
// Valid/tag/data arrays: asynchronous read, synchronous single-port write.
// Valid bits are individual flops so a fence can clear them all in one cycle.
module icache_store
   import icache_pkg::*;
#(
   parameter  int INDEX_W = ICACHE_INDEX_W,
   localparam int TAG_W   = 30 - INDEX_W,
   localparam int LINES   = 1 << INDEX_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_i,
   input  logic               we_i,
   input  logic [INDEX_W-1:0] widx_i,
   input  logic [TAG_W-1:0]   wtag_i,
   input  logic [31:0]        wdata_i,
   input  logic [INDEX_W-1:0] ridx_i,
   output logic               rvalid_o,
   output logic [TAG_W-1:0]   rtag_o,
   output logic [31:0]        rdata_o
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   always_ff @(posedge clk) begin
      if (rst || clr_i) valid_q <= '0;
      else if (we_i)    valid_q[widx_i] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[widx_i]  <= wtag_i;
         data_q[widx_i] <= wdata_i;
      end
   end

   assign rvalid_o = valid_q[ridx_i];
   assign rtag_o   = tag_q[ridx_i];
   assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetcher and memctrl's INF port.
// Build macro ICACHE_PERF_EN adds saturating oHIT_cnt / oMISS_cnt ports.
module icache
   import icache_pkg::*;
#(
   parameter  int INDEX_W = ICACHE_INDEX_W,
   localparam int TAG_W   = 30 - INDEX_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   icache_if.slave     bus
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] oHIT_cnt,
   output logic [31:0] oMISS_cnt
`endif
);

   ic_state_e          state_q;
   logic [29:0]        miss_pc_q;
   logic               if_valid_q;
   logic [31:0]        if_inst_q;
   logic               mc_en_q;

   logic [INDEX_W-1:0] ridx;
   logic [TAG_W-1:0]   rtag_pc;
   logic               rvalid;
   logic [TAG_W-1:0]   rtag;
   logic [31:0]        rdata;
   logic               hit;
   logic               abort;
   logic               lookup;
   logic               fill_we;
   logic               clr;
   logic [1:0]         unused_pc_lsb;

   assign ridx          = bus.iIF_pc[INDEX_W+1:2];
   assign rtag_pc       = bus.iIF_pc[31:INDEX_W+2];
   assign unused_pc_lsb = bus.iIF_pc[1:0];

   assign hit    = rvalid && (rtag == rtag_pc);
   assign abort  = bus.iFLUSH || bus.iCLEAR;
   assign lookup = rdy && (state_q == IC_IDLE) && bus.iIF_en && !abort;
   // A fill survives a flush (data is right for its address) but not a fence.
   assign fill_we = rdy && !rst && (state_q == IC_MISS) && bus.iMC_done && !bus.iCLEAR;
   assign clr     = rdy && bus.iCLEAR;

   icache_store #(.INDEX_W(INDEX_W)) u_store (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr),
      .we_i     (fill_we),
      .widx_i   (miss_pc_q[INDEX_W-1:0]),
      .wtag_i   (miss_pc_q[29:INDEX_W]),
      .wdata_i  (bus.iMC_inst),
      .ridx_i   (ridx),
      .rvalid_o (rvalid),
      .rtag_o   (rtag),
      .rdata_o  (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IC_IDLE;
         miss_pc_q  <= '0;
         if_valid_q <= 1'b0;
         if_inst_q  <= '0;
         mc_en_q    <= 1'b0;
      end else if (rdy) begin
         if (abort) begin
            // Dropping the enable makes memctrl discard any partial fetch.
            state_q    <= IC_IDLE;
            if_valid_q <= 1'b0;
            mc_en_q    <= 1'b0;
         end else begin
            case (state_q)
               IC_IDLE: begin
                  if_valid_q <= 1'b0;
                  if (bus.iIF_en) begin
                     if (hit) begin
                        if_valid_q <= 1'b1;
                        if_inst_q  <= rdata;
                     end else begin
                        miss_pc_q <= bus.iIF_pc[31:2];
                        mc_en_q   <= 1'b1;
                        state_q   <= IC_MISS;
                     end
                  end
               end
               IC_MISS: begin
                  if_valid_q <= 1'b0;
                  if (bus.iMC_done) begin
                     mc_en_q    <= 1'b0;
                     if_valid_q <= 1'b1;
                     if_inst_q  <= bus.iMC_inst;
                     state_q    <= IC_IDLE;
                  end
               end
               default: state_q <= IC_IDLE;
            endcase
         end
      end
   end

   assign bus.oIF_valid = if_valid_q;
   assign bus.oIF_inst  = if_inst_q;
   assign bus.oMC_en    = mc_en_q;
   assign bus.oMC_addr  = ic_word_addr(miss_pc_q);

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (lookup && hit && (hit_cnt_q != '1))    hit_cnt_d  = hit_cnt_q + 32'd1;
      if (lookup && !hit && (miss_cnt_q != '1))  miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (rdy) begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign oHIT_cnt  = hit_cnt_q;
   assign oMISS_cnt = miss_cnt_q;
`else
   logic unused_lookup;
   assign unused_lookup = lookup;
`endif

endmodule
